// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
// Keeps the PC, fetches one word at a time over a req/ready handshake,
// freezes on stall_pc, and redirects on taken branches, discarding any
// wrong-path fetch that is already in flight.
// Optional feature macro: FETCH_MISALIGN_EXC_EN (adds exc_misaligned and
// stops fetching at a misaligned PC instead of masking address bits).
//
// Handshake: imem_req is a valid-style request. Once raised, imem_addr
// stays fixed until a cycle in which imem_ready is sampled high; that
// cycle completes the transfer (imem_ready may already be high in the
// first request cycle). The response cannot be refused. A reset abandons
// any open request.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_1000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] ir,
  output logic [31:0] next_pc,
  output logic        valid,
  output logic        fetch_busy,
`ifdef FETCH_MISALIGN_EXC_EN
  output logic        exc_misaligned,
`endif
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_KILL  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] hold_buf_q, hold_buf_d;
  logic [31:0] hold_pc_q, hold_pc_d;
  logic [31:0] ir_q, next_pc_q;
  logic        valid_q;

  // IF/ID load request and the values to load.
  logic        ifid_load;
  logic [31:0] ld_ir, ld_next_pc;
  logic        ld_valid;

`ifdef FETCH_MISALIGN_EXC_EN
  logic misaligned;
  logic exc_q, exc_set;
  assign misaligned = (req_addr_q[1:0] != 2'b00);
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state logic; stall_pc outranks branch_taken everywhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
`ifdef FETCH_MISALIGN_EXC_EN
        if (misaligned) state_d = S_FETCH;
        else
`endif
        if (imem_ready) state_d = stall_pc ? S_HOLD : S_FETCH;
        else if (!stall_pc && branch_taken) state_d = S_KILL;
      end
      S_HOLD:  if (!stall_pc) state_d = S_FETCH;
      S_KILL:  if (imem_ready) state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  // Output logic: request only in FETCH/KILL and never during reset.
  always_comb begin
    imem_req = reset && (state_q == S_KILL || state_q == S_FETCH);
`ifdef FETCH_MISALIGN_EXC_EN
    if (state_q == S_FETCH && misaligned) imem_req = 1'b0;
    imem_addr = req_addr_q;
`else
    imem_addr = {req_addr_q[31:2], 2'b00};
`endif
    fetch_busy = imem_req && !imem_ready;
    dbg_state  = state_q;
  end

  // Datapath next-state: PC, request address, hold buffer, IF/ID load.
  always_comb begin
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    hold_buf_d = hold_buf_q;
    hold_pc_d  = hold_pc_q;
    ifid_load  = 1'b0;
    ld_ir      = NOP_INSTR;
    ld_valid   = 1'b0;
    ld_next_pc = next_pc_q;
`ifdef FETCH_MISALIGN_EXC_EN
    exc_set    = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
`ifdef FETCH_MISALIGN_EXC_EN
        if (misaligned) begin
          // No request; report once, then idle until redirected.
          if (!stall_pc) begin
            if (branch_taken) begin
              ifid_load  = 1'b1;
              pc_d       = branch_target;
              req_addr_d = branch_target;
            end else if (!exc_q) begin
              ifid_load  = 1'b1;
              ld_valid   = 1'b1;
              ld_next_pc = req_addr_q;
              exc_set    = 1'b1;
            end
          end
        end else
`endif
        begin
          if (imem_ready) begin
            if (stall_pc) begin
              // Park the word; IF/ID stays frozen.
              hold_buf_d = imem_data;
              hold_pc_d  = req_addr_q + 32'd4;
              pc_d       = req_addr_q + 32'd4;
            end else if (branch_taken) begin
              // Wrong-path word: drop it and redirect.
              ifid_load  = 1'b1;
              pc_d       = branch_target;
              req_addr_d = branch_target;
            end else begin
              ifid_load  = 1'b1;
              ld_ir      = imem_data;
              ld_valid   = 1'b1;
              ld_next_pc = req_addr_q + 32'd4;
              pc_d       = req_addr_q + 32'd4;
              req_addr_d = req_addr_q + 32'd4;
            end
          end else if (!stall_pc) begin
            // Waiting on memory: bubble; a branch must let the request finish.
            ifid_load = 1'b1;
            if (branch_taken) pc_d = branch_target;
          end
        end
      end
      S_HOLD: begin
        if (!stall_pc) begin
          ifid_load = 1'b1;
          if (branch_taken) begin
            pc_d       = branch_target;
            req_addr_d = branch_target;
          end else begin
            ld_ir      = hold_buf_q;
            ld_valid   = 1'b1;
            ld_next_pc = hold_pc_q;
            req_addr_d = pc_q;
          end
        end
      end
      S_KILL: begin
        // Old request still open; its data is discarded. Latest target wins.
        if (!stall_pc) begin
          ifid_load = 1'b1;
          if (branch_taken) pc_d = branch_target;
        end
        if (imem_ready) req_addr_d = (!stall_pc && branch_taken) ? branch_target : pc_q;
      end
      default: ;
    endcase
  end

  // Datapath and IF/ID registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
      hold_buf_q <= 32'd0;
      hold_pc_q  <= 32'd0;
      ir_q       <= NOP_INSTR;
      next_pc_q  <= 32'd0;
      valid_q    <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      hold_buf_q <= hold_buf_d;
      hold_pc_q  <= hold_pc_d;
      if (ifid_load) begin
        ir_q      <= ld_ir;
        next_pc_q <= ld_next_pc;
        valid_q   <= ld_valid;
      end
    end
  end

`ifdef FETCH_MISALIGN_EXC_EN
  // Misalignment flag follows every IF/ID load.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         exc_q <= 1'b0;
    else if (ifid_load) exc_q <= exc_set;
  end
  assign exc_misaligned = exc_q;
`endif

  assign ir      = ir_q;
  assign next_pc = next_pc_q;
  assign valid   = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed bench for fetch_stage. Inputs change on the
// falling edge; outputs are sampled 1 time unit later.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic        stall_pc;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] ir;
  logic [31:0] next_pc;
  logic        valid;
  logic        fetch_busy;
  logic [1:0]  dbg_state;
`ifdef FETCH_MISALIGN_EXC_EN
  logic        exc_misaligned;
`endif

  int total = 0;
  int bad   = 0;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_pc      (stall_pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_data     (imem_data),
    .ir            (ir),
    .next_pc       (next_pc),
    .valid         (valid),
    .fetch_busy    (fetch_busy),
`ifdef FETCH_MISALIGN_EXC_EN
    .exc_misaligned(exc_misaligned),
`endif
    .dbg_state     (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  // Reset driver: leaves the bench on a falling edge with reset released.
  task automatic do_reset();
    reset = 1'b0; stall_pc = 1'b0; branch_taken = 1'b0;
    branch_target = 32'd0; imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; stall_pc = 1'b0; branch_taken = 1'b0;
    branch_target = 32'd0; imem_ready = 1'b0;
    @(negedge clk); #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
    total++; if (ir !== NOP) begin bad++; $display("FAIL rst_ir: got %h want %h", ir, NOP); end
    total++; if (next_pc !== 32'd0) begin bad++; $display("FAIL rst_next_pc: got %h want 0", next_pc); end
    total++; if (imem_addr !== 32'h1000) begin bad++; $display("FAIL rst_addr: got %h want 1000", imem_addr); end
    reset = 1'b1; #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL rel_req: got %b want 1", imem_req); end
    total++; if (fetch_busy !== 1'b1) begin bad++; $display("FAIL rel_busy: got %b want 1", fetch_busy); end
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    do_reset(); imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h1000 + 32'(4 * i);
      #1;
      total++; if (imem_addr !== a) begin bad++; $display("FAIL zw_addr%0d: got %h want %h", i, imem_addr, a); end
      total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL zw_req%0d: got %b want 1", i, imem_req); end
      @(negedge clk); #1;
      total++; if (valid !== 1'b1) begin bad++; $display("FAIL zw_valid%0d: got %b want 1", i, valid); end
      total++; if (ir !== mem_word(a)) begin bad++; $display("FAIL zw_ir%0d: got %h want %h", i, ir, mem_word(a)); end
      total++; if (next_pc !== a + 32'd4) begin bad++; $display("FAIL zw_npc%0d: got %h want %h", i, next_pc, a + 32'd4); end
    end
  endtask

  task automatic test_latency();
    do_reset(); imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (imem_addr !== 32'h1000) begin bad++; $display("FAIL lat_addr%0d: got %h want 1000", i, imem_addr); end
      total++; if (fetch_busy !== 1'b1) begin bad++; $display("FAIL lat_busy%0d: got %b want 1", i, fetch_busy); end
      total++; if (valid !== 1'b0) begin bad++; $display("FAIL lat_valid%0d: got %b want 0", i, valid); end
      @(negedge clk);
    end
    imem_ready = 1'b1; #1;
    total++; if (imem_req !== 1'b1) begin bad++; $display("FAIL lat_req3: got %b want 1", imem_req); end
    total++; if (fetch_busy !== 1'b0) begin bad++; $display("FAIL lat_busy3: got %b want 0", fetch_busy); end
    @(negedge clk); imem_ready = 1'b0; #1;
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b want 1", valid); end
    total++; if (ir !== mem_word(32'h1000)) begin bad++; $display("FAIL lat_ir: got %h want %h", ir, mem_word(32'h1000)); end
    total++; if (next_pc !== 32'h1004) begin bad++; $display("FAIL lat_npc: got %h want 1004", next_pc); end
    total++; if (imem_addr !== 32'h1004) begin bad++; $display("FAIL lat_addr_next: got %h want 1004", imem_addr); end
    @(negedge clk); #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL lat_bubble_valid: got %b want 0", valid); end
    total++; if (ir !== NOP) begin bad++; $display("FAIL lat_bubble_ir: got %h want %h", ir, NOP); end
  endtask

  task automatic test_stall_hold();
    do_reset(); imem_ready = 1'b1;
    @(negedge clk);
    // Stall and a branch arrive with the 0x1004 response; stall wins.
    stall_pc = 1'b1; branch_taken = 1'b1; branch_target = 32'h3000; #1;
    total++; if (imem_addr !== 32'h1004) begin bad++; $display("FAIL st_addr: got %h want 1004", imem_addr); end
    @(negedge clk); branch_taken = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) stall_pc = 1'b0;
      #1;
      total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL st_state%0d: got %0d want 1", i, dbg_state); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL st_req%0d: got %b want 0", i, imem_req); end
      total++; if (ir !== mem_word(32'h1000) || valid !== 1'b1) begin bad++; $display("FAIL st_frozen%0d: got ir=%h v=%b want ir=%h v=1", i, ir, valid, mem_word(32'h1000)); end
      total++; if (next_pc !== 32'h1004) begin bad++; $display("FAIL st_npc%0d: got %h want 1004", i, next_pc); end
      @(negedge clk);
    end
    #1;
    total++; if (ir !== 32'hDEAD_BEEF) begin bad++; $display("FAIL st_ir: got %h want deadbeef", ir); end
    total++; if (next_pc !== 32'h1008) begin bad++; $display("FAIL st_npc_rel: got %h want 1008", next_pc); end
    total++; if (valid !== 1'b1) begin bad++; $display("FAIL st_valid_rel: got %b want 1", valid); end
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1008) begin bad++; $display("FAIL st_refetch: got req=%b addr=%h want req=1 addr=1008", imem_req, imem_addr); end
  endtask

  task automatic test_branch_kill();
    do_reset(); imem_ready = 1'b1;
    repeat (2) @(negedge clk);
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h2000; #1;
    total++; if (ir !== 32'hDEAD_BEEF || valid !== 1'b1) begin bad++; $display("FAIL bk_pre: got ir=%h v=%b want deadbeef v=1", ir, valid); end
    total++; if (imem_addr !== 32'h1008 || fetch_busy !== 1'b1) begin bad++; $display("FAIL bk_out: got addr=%h busy=%b want 1008 1", imem_addr, fetch_busy); end
    @(negedge clk); branch_taken = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 1) imem_ready = 1'b1;
      #1;
      total++; if (dbg_state !== 2'd2) begin bad++; $display("FAIL bk_state%0d: got %0d want 2", i, dbg_state); end
      total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1008) begin bad++; $display("FAIL bk_hold%0d: got req=%b addr=%h want 1 1008", i, imem_req, imem_addr); end
      total++; if (valid !== 1'b0 || ir !== NOP) begin bad++; $display("FAIL bk_bubble%0d: got v=%b ir=%h want 0 %h", i, valid, ir, NOP); end
      @(negedge clk);
    end
    #1;
    total++; if (imem_addr !== 32'h2000 || imem_req !== 1'b1) begin bad++; $display("FAIL bk_redir: got addr=%h req=%b want 2000 1", imem_addr, imem_req); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL bk_discard: got %b want 0", valid); end
    @(negedge clk); #1;
    total++; if (valid !== 1'b1 || ir !== mem_word(32'h2000)) begin bad++; $display("FAIL bk_ir: got v=%b ir=%h want 1 %h", valid, ir, mem_word(32'h2000)); end
    total++; if (next_pc !== 32'h2004) begin bad++; $display("FAIL bk_npc: got %h want 2004", next_pc); end
  endtask

  task automatic test_reset_mid_wait();
    do_reset(); imem_ready = 1'b1;
    @(negedge clk); imem_ready = 1'b0; #1;
    total++; if (valid !== 1'b1 || fetch_busy !== 1'b1) begin bad++; $display("FAIL rm_pre: got v=%b busy=%b want 1 1", valid, fetch_busy); end
    #2 reset = 1'b0; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rm_req: got %b want 0", imem_req); end
    total++; if (valid !== 1'b0 || ir !== NOP) begin bad++; $display("FAIL rm_ifid: got v=%b ir=%h want 0 %h", valid, ir, NOP); end
    total++; if (next_pc !== 32'd0) begin bad++; $display("FAIL rm_npc: got %h want 0", next_pc); end
    @(negedge clk); reset = 1'b1; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h1000) begin bad++; $display("FAIL rm_restart: got req=%b addr=%h want 1 1000", imem_req, imem_addr); end
  endtask

  task automatic test_wrap();
    do_reset(); imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    @(negedge clk); branch_taken = 1'b0; #1;
    total++; if (imem_addr !== 32'hFFFF_FFFC || valid !== 1'b0) begin bad++; $display("FAIL wr_addr: got addr=%h v=%b want fffffffc 0", imem_addr, valid); end
    @(negedge clk); #1;
    total++; if (ir !== mem_word(32'hFFFF_FFFC) || valid !== 1'b1) begin bad++; $display("FAIL wr_ir: got ir=%h v=%b want %h 1", ir, valid, mem_word(32'hFFFF_FFFC)); end
    total++; if (next_pc !== 32'd0 || imem_addr !== 32'd0) begin bad++; $display("FAIL wr_npc: got npc=%h addr=%h want 0 0", next_pc, imem_addr); end
  endtask

  task automatic test_misalign();
    do_reset(); imem_ready = 1'b1; branch_taken = 1'b1; branch_target = 32'h2002;
    @(negedge clk); branch_taken = 1'b0; #1;
`ifdef FETCH_MISALIGN_EXC_EN
    total++; if (imem_req !== 1'b0 || exc_misaligned !== 1'b0) begin bad++; $display("FAIL ma_noreq: got req=%b exc=%b want 0 0", imem_req, exc_misaligned); end
    @(negedge clk); #1;
    total++; if (exc_misaligned !== 1'b1 || valid !== 1'b1 || ir !== NOP) begin bad++; $display("FAIL ma_exc: got exc=%b v=%b ir=%h want 1 1 %h", exc_misaligned, valid, ir, NOP); end
    total++; if (next_pc !== 32'h2002) begin bad++; $display("FAIL ma_npc: got %h want 2002", next_pc); end
    @(negedge clk); branch_taken = 1'b1; branch_target = 32'h3000; #1;
    total++; if (imem_req !== 1'b0 || exc_misaligned !== 1'b1) begin bad++; $display("FAIL ma_idle: got req=%b exc=%b want 0 1", imem_req, exc_misaligned); end
    @(negedge clk); branch_taken = 1'b0; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h3000) begin bad++; $display("FAIL ma_resume: got req=%b addr=%h want 1 3000", imem_req, imem_addr); end
    total++; if (exc_misaligned !== 1'b0) begin bad++; $display("FAIL ma_clear: got %b want 0", exc_misaligned); end
    @(negedge clk); #1;
    total++; if (ir !== mem_word(32'h3000) || next_pc !== 32'h3004) begin bad++; $display("FAIL ma_ir: got ir=%h npc=%h want %h 3004", ir, next_pc, mem_word(32'h3000)); end
`else
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) begin bad++; $display("FAIL ma_mask: got req=%b addr=%h want 1 2000", imem_req, imem_addr); end
    @(negedge clk); #1;
    total++; if (ir !== mem_word(32'h2000) || valid !== 1'b1) begin bad++; $display("FAIL ma_ir: got ir=%h v=%b want %h 1", ir, valid, mem_word(32'h2000)); end
    total++; if (next_pc !== 32'h2006) begin bad++; $display("FAIL ma_npc: got %h want 2006", next_pc); end
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_branch_kill();
    test_reset_mid_wait();
    test_wrap();
    test_misalign();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch (IF) stage and IF/ID pipeline register. Sits directly upstream of the decoder and feeds it `ir` and `next_pc`.
- Holds the PC and issues word fetches to the instruction memory/cache over a request/ready handshake.
- Honours the pipeline-wide `stall_pc` freeze and redirects on taken branches resolved in EX, squashing wrong-path fetches.

Parameters:
RESET_PC, 32'h0000_1000, PC value loaded on reset (boot address)
NOP_INSTR, 32'h0000_0000, encoding driven on ir when no valid instruction is held

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
stall_pc  input  1  pipeline freeze from MEM stage; IF/ID outputs and PC hold while high
branch_taken  input  1  EX-stage redirect request; sampled only when stall_pc=0
branch_target  input  32  redirect PC, valid with branch_taken
imem_req  output  1  fetch request; held high until imem_ready sampled high
imem_addr  output  32  fetch address; stable while imem_req high
imem_ready  input  1  response strobe; may be high in the same cycle as imem_req (zero-wait)
imem_data  input  32  instruction word, valid when imem_ready=1
ir  output  32  IF/ID instruction to decoder
next_pc  output  32  IF/ID PC+4 of the instruction in ir
valid  output  1  ir/next_pc hold a real instruction (0 = bubble)
fetch_busy  output  1  imem_req && !imem_ready; fetch outstanding this cycle

Behaviour:
- Reset (reset=0, async): pc=RESET_PC, req_addr=RESET_PC, state=FETCH, ir=NOP_INSTR, next_pc=0, valid=0, hold buffer empty. imem_req=0 while reset is asserted. After release, FETCH drives imem_req=1 combinationally.
- Registers:
  - pc: next address to fetch.
  - req_addr: address of the in-flight request; imem_addr=req_addr.
  - hold_buf: 32-bit, with hold_pc.
- States: FETCH, HOLD, KILL.
- FETCH (imem_req=1):
  - ready & !stall & !branch: ir<=imem_data, next_pc<=req_addr+4, valid<=1, pc=req_addr<=req_addr+4; stay. This gives 1 instr/cycle with zero-wait memory.
  - ready & stall: hold_buf<=imem_data, hold_pc<=req_addr+4, pc<=req_addr+4; IF/ID unchanged; ->HOLD.
  - ready & !stall & branch: discard data; valid<=0, ir<=NOP_INSTR; pc=req_addr<=branch_target; stay.
  - !ready & !stall & !branch: valid<=0, ir<=NOP_INSTR (bubble); req held.
  - !ready & !stall & branch: valid<=0; pc<=branch_target; ->KILL (the in-flight request must complete).
  - !ready & stall: nothing changes.
- HOLD (imem_req=0):
  - stall: hold.
  - !stall & !branch: ir<=hold_buf, next_pc<=hold_pc, valid<=1, req_addr<=pc; ->FETCH.
  - !stall & branch: drop buffer, valid<=0, ir<=NOP_INSTR, pc=req_addr<=branch_target; ->FETCH.
- KILL (imem_req=1, old req_addr):
  - on imem_ready: discard data, req_addr<=pc; ->FETCH.
  - branch_taken in KILL (stall=0): pc<=branch_target, so the latest target wins.
  - valid=0 throughout KILL unless stall holds it.
- Arithmetic: PC+4 modulo 2^32. 32'hFFFF_FFFC wraps to 0 with no flag.
- Simultaneous events: stall_pc has priority over branch_taken; a branch is ignored while stalled, and EX holds it. Reset mid-request abandons it and memory must tolerate a dropped req.
- imem_addr never changes while imem_req=1 and imem_ready=0.

Optional Feature:
- FETCH_MISALIGN_EXC_EN.
- Defined:
  - Adds output exc_misaligned (1 bit, reset 0).
  - If FETCH would issue a request with req_addr[1:0]!=0, no request is issued (imem_req=0).
  - IF/ID loads ir=NOP_INSTR, valid=1, exc_misaligned=1, next_pc=req_addr.
  - The stage then idles in FETCH without requesting until branch_taken redirects it; exc_misaligned clears on the next IF/ID load.
- Undefined: no port; address bits [1:0] are ignored (forced to 0 on imem_addr).

Test Plan:
- Zero-wait memory (ready tied 1), reset released → imem_addr 0x1000,0x1004,0x1008 on consecutive cycles; ir follows the data with valid=1, next_pc=0x1004,0x1008,0x100C.
- Memory with 3-cycle latency at 0x1000 → imem_req high 3 cycles, addr stable, fetch_busy=1 for 2 cycles, valid=0 bubbles, then ir=data and next_pc=0x1004.
- stall_pc high the cycle ready arrives for 0x1004 (data 0xDEADBEEF), stall held 4 cycles → ir/valid frozen, imem_req=0 in HOLD, then ir=0xDEADBEEF, next_pc=0x1008 the cycle after stall drops.
- Branch to 0x2000 while the fetch of 0x1008 is outstanding → request completes at 0x1008 and is discarded (valid stays 0), next request at 0x2000, ir from 0x2000 with next_pc=0x2004.
- Reset asserted mid-wait → outputs immediately ir=NOP_INSTR, valid=0, imem_req=0; after release, fetch restarts at 0x1000.
- FETCH_MISALIGN_EXC_EN: branch to 0x2002 → no imem_req, exc_misaligned=1, next_pc=0x2002; branch to 0x3000 resumes fetching and clears the flag.
